// File: rtl/path_meter_pkg.sv
// Shared types and helpers for path_delay_meter: FSM state encoding, the minimum
// synchroniser depth and the expected chain output level for a given launch level.
package path_meter_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRIME,
    LAUNCH,
    WAIT,
    NEXT,
    FINISH
  } meterState_t;

  localparam int MIN_SYNC_STAGES = 2;

  function automatic logic expectedLevel(input logic launchLevel, input logic inverting);
    return launchLevel ^ inverting;
  endfunction

endpackage

// File: rtl/path_result_sync.sv
// Multi-flop synchroniser that brings the asynchronous chain output into the clk domain.
module path_result_sync
  import path_meter_pkg::*;
#(
  parameter int SYNC_STAGES = MIN_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic asyncIn,
  output logic syncOut
);

  (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] syncFf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      syncFf <= '0;
    end else begin
      syncFf <= {syncFf[SYNC_STAGES-2:0], asyncIn};
    end
  end

  assign syncOut = syncFf[SYNC_STAGES-1];

endmodule

// File: rtl/path_delay_meter.sv
// Launches alternating edges into an external delay chain and averages the synchronised
// response time over 2^TRIALS_LOG2 trials. Define EDGE_SPLIT_EN to add riseAvg/fallAvg.
module path_delay_meter
  import path_meter_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 1023,
  parameter int TRIALS_LOG2 = 3,
  parameter int INVERTING   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             pathInput,
  input  logic             pathResult,
  output logic             busy,
  output logic             done,
  output logic             timeoutFlag,
  output logic [CNT_W-1:0] delayAvg
`ifdef EDGE_SPLIT_EN
  ,
  output logic [CNT_W-1:0] riseAvg,
  output logic [CNT_W-1:0] fallAvg
`endif
);

  localparam int ACC_W = CNT_W + TRIALS_LOG2;
  localparam int IDX_W = TRIALS_LOG2 + 1;
  localparam logic [IDX_W-1:0] LAST_TRIAL = IDX_W'((1 << TRIALS_LOG2) - 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT  = CNT_W'(TIMEOUT);
  localparam logic             INV_LVL    = (INVERTING != 0);

  meterState_t      state, nextState;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] trialIdx;
  logic [ACC_W-1:0] acc, accSum;
  logic             resultSync, atLevel, atLimit;
  logic             startNow, launchNow, countEn, trialTimeout, accumulate, finishNow;

  path_result_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) uSync (
    .clk    (clk),
    .rst_n  (rst_n),
    .asyncIn(pathResult),
    .syncOut(resultSync)
  );

  assign atLevel = (resultSync == expectedLevel(pathInput, INV_LVL));
  assign atLimit = (cnt == CNT_LIMIT);
  assign accSum  = acc + ACC_W'(cnt);

  // pathInput flips on the edge entering LAUNCH, so LAUNCH is cycle 0 of the trial count
  always_comb begin
    nextState    = state;
    startNow     = 1'b0;
    launchNow    = 1'b0;
    countEn      = 1'b0;
    trialTimeout = 1'b0;
    accumulate   = 1'b0;
    finishNow    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          nextState = PRIME;
          startNow  = 1'b1;
        end
      end
      PRIME, WAIT: begin
        if (atLevel || atLimit) begin
          nextState    = (state == PRIME) ? LAUNCH : NEXT;
          launchNow    = (state == PRIME);
          trialTimeout = !atLevel;
        end else begin
          countEn = 1'b1;
        end
      end
      LAUNCH: begin
        nextState = WAIT;
        countEn   = 1'b1;
      end
      NEXT: begin
        accumulate = 1'b1;
        if (trialIdx == LAST_TRIAL) begin
          nextState = FINISH;
          finishNow = 1'b1;
        end else begin
          nextState = LAUNCH;
          launchNow = 1'b1;
        end
      end
      FINISH:  nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pathInput   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeoutFlag <= 1'b0;
      cnt         <= '0;
      trialIdx    <= '0;
      acc         <= '0;
      delayAvg    <= '0;
    end else begin
      state <= nextState;
      done  <= finishNow;
      if (startNow) busy <= 1'b1;
      else if (finishNow) busy <= 1'b0;
      if (startNow) timeoutFlag <= 1'b0;
      else if (trialTimeout) timeoutFlag <= 1'b1;
      if (launchNow) pathInput <= ~pathInput;
      if (startNow || launchNow) cnt <= '0;
      else if (countEn) cnt <= cnt + CNT_W'(1);
      if (startNow) begin
        trialIdx <= '0;
        acc      <= '0;
      end else if (accumulate) begin
        trialIdx <= trialIdx + IDX_W'(1);
        acc      <= accSum;
      end
      if (finishNow) delayAvg <= accSum[ACC_W-1:TRIALS_LOG2];
    end
  end

`ifdef EDGE_SPLIT_EN
  localparam int SPLIT_W = ACC_W - 1;

  logic [SPLIT_W-1:0] riseAcc, fallAcc, riseSum, fallSum;

  // pathInput still holds the level launched for the trial being accumulated
  assign riseSum = riseAcc + (pathInput ? SPLIT_W'(cnt) : '0);
  assign fallSum = fallAcc + (pathInput ? '0 : SPLIT_W'(cnt));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      riseAcc <= '0;
      fallAcc <= '0;
      riseAvg <= '0;
      fallAvg <= '0;
    end else begin
      if (startNow) begin
        riseAcc <= '0;
        fallAcc <= '0;
      end else if (accumulate) begin
        riseAcc <= riseSum;
        fallAcc <= fallSum;
      end
      if (finishNow) begin
        riseAvg <= riseSum[SPLIT_W-1:TRIALS_LOG2-1];
        fallAvg <= fallSum[SPLIT_W-1:TRIALS_LOG2-1];
      end
    end
  end
`endif

endmodule

// File: tb/tb_path_delay_meter.sv
// Bench for path_delay_meter: two instances (non-inverting with TIMEOUT=20, inverting),
// each wrapped by a clocked transport-delay chain model; results come from a trial-level model.
module tb_path_delay_meter;

  localparam int CNT_W  = 16;
  localparam int SYNC   = 2;
  localparam int TMO0   = 20;
  localparam int TMO1   = 1023;
  localparam int TRIALS = 8;

  logic clk = 1'b0;
  logic rst_n, start0, start1;
  logic pathInput0, pathInput1, pathResult0, pathResult1;
  logic busy0, busy1, done0, done1, tf0, tf1;
  logic [CNT_W-1:0] avg0, avg1;
`ifdef EDGE_SPLIT_EN
  logic [CNT_W-1:0] rise0, fall0, rise1, fall1;
`endif

  int vectors = 0;
  int fails   = 0;
  int riseDly = 5;
  int fallDly = 5;
  bit stuck0  = 1'b0;
  bit [63:0] hist0 = '0;
  bit [63:0] hist1 = '0;
  logic lastPi0 = 1'b0;
  logic lastPi1 = 1'b0;
  int togTot0 = 0, togTot1 = 0, doneTot0 = 0, doneTot1 = 0;

  always #5 clk = ~clk;

  path_delay_meter #(
    .CNT_W(CNT_W), .SYNC_STAGES(SYNC), .TIMEOUT(TMO0), .TRIALS_LOG2(3), .INVERTING(0)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .pathInput(pathInput0), .pathResult(pathResult0),
    .busy(busy0), .done(done0), .timeoutFlag(tf0), .delayAvg(avg0)
`ifdef EDGE_SPLIT_EN
    , .riseAvg(rise0), .fallAvg(fall0)
`endif
  );

  path_delay_meter #(
    .CNT_W(CNT_W), .SYNC_STAGES(SYNC), .TIMEOUT(TMO1), .TRIALS_LOG2(3), .INVERTING(1)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .pathInput(pathInput1), .pathResult(pathResult1),
    .busy(busy1), .done(done1), .timeoutFlag(tf1), .delayAvg(avg1)
`ifdef EDGE_SPLIT_EN
    , .riseAvg(rise1), .fallAvg(fall1)
`endif
  );

  // Chain models: output follows the launch level riseDly/fallDly clocks after it changes.
  always @(posedge clk) begin
    hist0 <= {hist0[62:0], pathInput0};
    hist1 <= {hist1[62:0], pathInput1};
  end

  always_comb begin
    if (stuck0) pathResult0 = 1'b0;
    else if (riseDly <= fallDly) pathResult0 = hist0[riseDly-1] | hist0[fallDly-1];
    else pathResult0 = hist0[riseDly-1] & hist0[fallDly-1];
  end

  assign pathResult1 = ~hist1[2];

  always @(posedge clk) begin
    lastPi0 <= pathInput0;
    lastPi1 <= pathInput1;
    if (rst_n === 1'b1 && pathInput0 !== lastPi0) togTot0 <= togTot0 + 1;
    if (rst_n === 1'b1 && pathInput1 !== lastPi1) togTot1 <= togTot1 + 1;
    if (done0 === 1'b1) doneTot0 <= doneTot0 + 1;
    if (done1 === 1'b1) doneTot1 <= doneTot1 + 1;
  end

  task automatic check(input string tag, input longint obs, input longint exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Trial-level model. arr = clocks after launch until the chain shows the new level
  // (0: already there, negative: never). The synchroniser adds SYNC clocks.
  task automatic refModel(input int arrRise, input int arrFall, input int tmo,
                          output int avg, output int rAvg, output int fAvg,
                          output int lat, output bit tflag);
    int riseSum, fallSum, c, arr;
    riseSum = 0;
    fallSum = 0;
    tflag   = 1'b0;
    for (int t = 0; t < TRIALS; t++) begin
      arr = (t % 2 == 0) ? arrRise : arrFall;
      if (arr == 0) c = 1;
      else if (arr < 0 || arr + SYNC > tmo) begin
        c = tmo;
        tflag = 1'b1;
      end else c = arr + SYNC;
      if (t % 2 == 0) riseSum += c;
      else fallSum += c;
    end
    avg  = (riseSum + fallSum) / TRIALS;
    rAvg = riseSum / (TRIALS / 2);
    fAvg = fallSum / (TRIALS / 2);
    lat  = riseSum + fallSum + 2 * TRIALS + 2;
  endtask

  task automatic measure(input int which, input bit repulse, input int arrRise,
                         input int arrFall, input int tmo, input string name);
    int lat, expAvg, expRise, expFall, expLat, togStart, doneStart;
    bit expTf, seen;
    refModel(arrRise, arrFall, tmo, expAvg, expRise, expFall, expLat, expTf);
    togStart  = which ? togTot1 : togTot0;
    doneStart = which ? doneTot1 : doneTot0;
    @(negedge clk);
    if (which != 0) start1 = 1'b1;
    else start0 = 1'b1;
    lat  = 0;
    seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      start0 = 1'b0;
      start1 = 1'b0;
      if (lat == 1) check($sformatf("%s.busyUp", name), which ? busy1 : busy0, 1);
      if (repulse && (lat == 3 || lat == 12 || lat == 25)) begin
        if (which != 0) start1 = 1'b1;
        else start0 = 1'b1;
      end
      seen = which ? done1 : done0;
    end
    check($sformatf("%s.doneSeen", name), seen, 1);
    check($sformatf("%s.latency", name), lat, expLat);
    check($sformatf("%s.delayAvg", name), which ? avg1 : avg0, expAvg);
    check($sformatf("%s.timeoutFlag", name), which ? tf1 : tf0, expTf);
    check($sformatf("%s.busyAtDone", name), which ? busy1 : busy0, 0);
`ifdef EDGE_SPLIT_EN
    check($sformatf("%s.riseAvg", name), which ? rise1 : rise0, expRise);
    check($sformatf("%s.fallAvg", name), which ? fall1 : fall0, expFall);
`endif
    repeat (30) @(negedge clk);
    check($sformatf("%s.doneCount", name), (which ? doneTot1 : doneTot0) - doneStart, 1);
    check($sformatf("%s.toggles", name), (which ? togTot1 : togTot0) - togStart, TRIALS);
    check($sformatf("%s.pathInputEnd", name), which ? pathInput1 : pathInput0, 0);
    check($sformatf("%s.doneLow", name), which ? done1 : done0, 0);
  endtask

  initial begin
    int togStart, doneStart, dr, df;
    rst_n  = 1'b0;
    start0 = 1'b0;
    start1 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst.pathInput", pathInput0, 0);
    check("rst.busy", busy0, 0);
    check("rst.done", done0, 0);
    check("rst.timeoutFlag", tf0, 0);
    check("rst.delayAvg", avg0, 0);
    check("rst.dut1.busy", busy1, 0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("idle.busy", busy0, 0);
    check("idle.pathInput", pathInput0, 0);

    riseDly = 5;
    fallDly = 5;
    measure(0, 1'b0, 5, 5, TMO0, "fixed5");

    // Asynchronous reset while in WAIT of the third trial
    togStart  = togTot0;
    doneStart = doneTot0;
    @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    for (int i = 0; i < 500 && (togTot0 - togStart) < 3; i++) @(negedge clk);
    check("midrst.reachedTrial3", togTot0 - togStart, 3);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst.pathInput", pathInput0, 0);
    check("midrst.busy", busy0, 0);
    check("midrst.done", done0, 0);
    check("midrst.timeoutFlag", tf0, 0);
    check("midrst.delayAvg", avg0, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("midrst.noDone", doneTot0 - doneStart, 0);
    check("midrst.idleBusy", busy0, 0);
    measure(0, 1'b0, 5, 5, TMO0, "afterRst");

    riseDly = 4;
    fallDly = 8;
    measure(0, 1'b0, 4, 8, TMO0, "rise4fall8");

    riseDly = 5;
    fallDly = 5;
    measure(0, 1'b1, 5, 5, TMO0, "restartIgnored");

    stuck0 = 1'b1;
    measure(0, 1'b0, -1, 0, TMO0, "stuckLow");
    stuck0 = 1'b0;
    repeat (20) @(negedge clk);

    for (int r = 0; r < 4; r++) begin
      dr = int'($urandom_range(10, 3));
      df = int'($urandom_range(10, 3));
      riseDly = dr;
      fallDly = df;
      repeat (20) @(negedge clk);
      measure(0, 1'b0, dr, df, TMO0, $sformatf("rand%0d_r%0d_f%0d", r, dr, df));
    end

    measure(1, 1'b0, 3, 3, TMO1, "inverting3");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
